// File: rtl/sirius_pkg.sv
// Shared types and constants for the sirius fetch front end.
//   RESET_PC_DEFAULT  first fetch address after reset
//   INST_NOP          instruction word carried by address-error markers
//   fetch_entry_t     one fetch-queue entry {pc, inst, adel}
package sirius_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            adel;
  } fetch_entry_t;

  // A fetch target is misaligned when its two low bits are not zero.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/sirius_fetch_if.sv
// Bundle of the fetch unit's memory, redirect and decode-side signals.
//   master: fetch unit (drives inst_req/inst_addr and the if_* payload)
//   slave : environment (instruction memory, redirect source, decode)
interface sirius_fetch_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  modport master (
    output inst_req, inst_addr,
    input  inst_data,
    input  redirect_valid, redirect_pc,
    output if_valid, if_pc, if_inst, if_adel,
    input  if_ready
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_data,
    output redirect_valid, redirect_pc,
    input  if_valid, if_pc, if_inst, if_adel,
    output if_ready
  );

endinterface

// File: rtl/sirius_fetch_buffer.sv
// Two-entry fetch queue of fetch_entry_t with a registered head.
//   clk, rst      clock, synchronous active-high reset
//   flush_i       empty the queue (wins over push_i)
//   push_i        append push_entry_i at the tail
//   pop_i         retire the head (only while valid_o)
//   count_o       occupancy 0..2
//   valid_o       head entry is valid
//   head_o        head entry, straight from a register
module sirius_fetch_buffer
  import sirius_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_entry_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic             valid_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t     head_q, head_d;
  fetch_entry_t     tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state: head slot always holds the oldest entry, tail the second.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (count_q == CNT_W'(0)) head_d = push_entry_i;
          else                      tail_d = push_entry_i;
          count_d = count_q + CNT_W'(1);
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - CNT_W'(1);
        end
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever remains.
          if (count_q == CNT_W'(1)) begin
            head_d = push_entry_i;
          end else begin
            head_d = tail_q;
            tail_d = push_entry_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != CNT_W'(0));
  assign head_o  = head_q;

endmodule

// File: rtl/sirius_fetch.sv
// Instruction-fetch front end: owns the PC, issues one word per cycle to a
// synchronous instruction memory, queues returns and hands {pc, inst, adel}
// to decode. Redirects flush and restart; misaligned targets yield one AdEL
// marker entry and halt fetch until the next redirect.
//   clk, rst   clock, synchronous active-high reset
//   bus        sirius_fetch_if.master: inst_req/inst_addr/inst_data,
//              redirect_valid/redirect_pc, if_valid/if_ready/if_pc/if_inst/if_adel
module sirius_fetch
  import sirius_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  sirius_fetch_if.master bus
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic             halted_q, halted_d;
  logic             adel_pend_q, adel_pend_d;

  logic [CNT_W-1:0] buf_count;
  logic             buf_valid;
  fetch_entry_t     buf_head;

  logic             pop;
  logic             issue;
  logic             push;
  logic             misaligned;
  logic [2:0]       occupancy;
  fetch_entry_t     push_entry;

  // Issue/push decisions; a redirect suppresses issue, push and pop.
  always_comb begin
    pop        = buf_valid && bus.if_ready;
    occupancy  = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
    misaligned = is_misaligned(bus.redirect_pc[1:0]);
    issue      = !rst && !halted_q && !bus.redirect_valid
                 && (occupancy < 3'(BUF_DEPTH));
    push       = !bus.redirect_valid && (inflight_q || adel_pend_q);
    // The AdEL marker is pushed the cycle after the redirect, while pc_q
    // already holds the faulting target and nothing is in flight.
    if (adel_pend_q) begin
      push_entry = '{pc: pc_q, inst: INST_NOP, adel: 1'b1};
    end else begin
      push_entry = '{pc: inflight_pc_q, inst: bus.inst_data, adel: 1'b0};
    end
  end

  // PC / in-flight / halt next-state.
  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = inflight_q;
    halted_d      = halted_q;
    adel_pend_d   = adel_pend_q;
    if (bus.redirect_valid) begin
      pc_d        = bus.redirect_pc;
      inflight_d  = 1'b0;
      halted_d    = misaligned;
      adel_pend_d = misaligned;
    end else begin
      inflight_d    = issue;
      inflight_pc_d = pc_q;
      adel_pend_d   = 1'b0;
      if (issue) pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      halted_q      <= 1'b0;
      adel_pend_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      halted_q      <= halted_d;
      adel_pend_q   <= adel_pend_d;
    end
  end

  sirius_fetch_buffer u_buffer (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (bus.redirect_valid),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop && !bus.redirect_valid),
    .count_o      (buf_count),
    .valid_o      (buf_valid),
    .head_o       (buf_head)
  );

  // Memory request depends on this cycle's redirect/ready, so it is combinational.
  assign bus.inst_req  = issue;
  assign bus.inst_addr = pc_q;

  assign bus.if_valid  = buf_valid;
  assign bus.if_pc     = buf_head.pc;
  assign bus.if_inst   = buf_head.inst;
  assign bus.if_adel   = buf_head.adel;

endmodule

// File: tb/tb_sirius_fetch.sv
module tb_sirius_fetch;
  import sirius_pkg::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] KEY    = 32'h5A5A_F00D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  sirius_fetch_if bus ();

  sirius_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: word for address A is A ^ KEY, returned the cycle after the request.
  always @(posedge clk)
    bus.inst_data <= bus.inst_req ? (bus.inst_addr ^ KEY) : 32'hDEAD_BEEF;

  // Hold reset for two edges, then release at a falling edge: the current cycle is cycle 0.
  task automatic start();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.if_ready       = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0002;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (bus.inst_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req: got %b want 0", bus.inst_req);
    end
    n_tests++;
    if ({bus.if_valid, bus.if_pc, bus.if_inst, bus.if_adel} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_out: got v=%b pc=%h inst=%h adel=%b want all 0",
               bus.if_valid, bus.if_pc, bus.if_inst, bus.if_adel);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_release: got req=%b addr=%h want req=1 addr=%h",
               bus.inst_req, bus.inst_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] e_pc;
    start();
    for (int k = 0; k < 8; k++) begin
      bus.if_ready = 1'b1;
      #1;
      e_pc = RST_PC + 32'(4 * (k - 2));
      n_tests++;
      if (bus.inst_req !== 1'b1 || bus.inst_addr !== RST_PC + 32'(4 * k)) begin
        n_fail++;
        $display("FAIL stream_req c%0d: got req=%b addr=%h want req=1 addr=%h",
                 k, bus.inst_req, bus.inst_addr, RST_PC + 32'(4 * k));
      end
      n_tests++;
      if (bus.if_valid !== (k >= 2) ||
          ((k >= 2) && {bus.if_pc, bus.if_inst, bus.if_adel} !== {e_pc, e_pc ^ KEY, 1'b0})) begin
        n_fail++;
        $display("FAIL stream_out c%0d: got v=%b pc=%h inst=%h adel=%b want v=%b pc=%h",
                 k, bus.if_valid, bus.if_pc, bus.if_inst, bus.if_adel, k >= 2, e_pc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    start();
    for (int k = 0; k < 13; k++) begin
      bus.if_ready = (k < 3) || (k > 7);
      #1;
      e_req  = (k < 3) || (k > 7);
      e_addr = (k < 3) ? RST_PC + 32'(4 * k) : RST_PC + 32'(4 * (k - 5));
      e_pc   = (k == 2) ? RST_PC : (k < 8) ? RST_PC + 32'd4 : RST_PC + 32'(4 * (k - 7));
      n_tests++;
      if (bus.inst_req !== e_req || (e_req && bus.inst_addr !== e_addr)) begin
        n_fail++;
        $display("FAIL bp_req c%0d: got req=%b addr=%h want req=%b addr=%h",
                 k, bus.inst_req, bus.inst_addr, e_req, e_addr);
      end
      n_tests++;
      if (bus.if_valid !== (k >= 2) ||
          ((k >= 2) && {bus.if_pc, bus.if_inst, bus.if_adel} !== {e_pc, e_pc ^ KEY, 1'b0})) begin
        n_fail++;
        $display("FAIL bp_out c%0d: got v=%b pc=%h inst=%h adel=%b want v=%b pc=%h",
                 k, bus.if_valid, bus.if_pc, bus.if_inst, bus.if_adel, k >= 2, e_pc);
      end
      @(negedge clk);
    end
  endtask

  // Redirect at cycle 3 with one entry queued, decode stalled and a fetch in flight.
  task automatic test_redirect_full();
    logic        e_req, e_v;
    logic [31:0] e_addr, e_pc;
    start();
    for (int k = 0; k < 9; k++) begin
      bus.if_ready       = (k != 3);
      bus.redirect_valid = (k == 3);
      bus.redirect_pc    = 32'h8000_0100;
      #1;
      e_req  = (k != 3);
      e_addr = (k < 3) ? RST_PC + 32'(4 * k) : 32'h8000_0100 + 32'(4 * (k - 4));
      e_v    = (k == 2) || (k == 3) || (k >= 6);
      e_pc   = (k == 2) ? RST_PC : (k == 3) ? RST_PC + 32'd4 : 32'h8000_0100 + 32'(4 * (k - 6));
      n_tests++;
      if (bus.inst_req !== e_req || (e_req && bus.inst_addr !== e_addr)) begin
        n_fail++;
        $display("FAIL redir_req c%0d: got req=%b addr=%h want req=%b addr=%h",
                 k, bus.inst_req, bus.inst_addr, e_req, e_addr);
      end
      n_tests++;
      if (bus.if_valid !== e_v ||
          (e_v && {bus.if_pc, bus.if_inst, bus.if_adel} !== {e_pc, e_pc ^ KEY, 1'b0})) begin
        n_fail++;
        $display("FAIL redir_out c%0d: got v=%b pc=%h inst=%h adel=%b want v=%b pc=%h",
                 k, bus.if_valid, bus.if_pc, bus.if_inst, bus.if_adel, e_v, e_pc);
      end
      @(negedge clk);
    end
    bus.redirect_valid = 1'b0;
  endtask

  // Misaligned redirect at 3, aligned redirect at 8.
  task automatic test_misaligned();
    logic        e_req, e_v, e_adel;
    logic [31:0] e_addr, e_pc, e_inst;
    start();
    for (int k = 0; k < 13; k++) begin
      bus.if_ready       = 1'b1;
      bus.redirect_valid = (k == 3) || (k == 8);
      bus.redirect_pc    = (k == 3) ? 32'h8000_0102 : 32'h8000_0200;
      #1;
      e_req  = (k < 3) || (k > 8);
      e_addr = (k < 3) ? RST_PC + 32'(4 * k) : 32'h8000_0200 + 32'(4 * (k - 9));
      e_v    = (k == 2) || (k == 3) || (k == 5) || (k >= 11);
      e_pc   = (k == 2) ? RST_PC : (k == 3) ? RST_PC + 32'd4 :
               (k == 5) ? 32'h8000_0102 : 32'h8000_0200 + 32'(4 * (k - 11));
      e_adel = (k == 5);
      e_inst = e_adel ? 32'h0 : e_pc ^ KEY;
      n_tests++;
      if (bus.inst_req !== e_req || (e_req && bus.inst_addr !== e_addr)) begin
        n_fail++;
        $display("FAIL adel_req c%0d: got req=%b addr=%h want req=%b addr=%h",
                 k, bus.inst_req, bus.inst_addr, e_req, e_addr);
      end
      n_tests++;
      if (bus.if_valid !== e_v ||
          (e_v && {bus.if_pc, bus.if_inst, bus.if_adel} !== {e_pc, e_inst, e_adel})) begin
        n_fail++;
        $display("FAIL adel_out c%0d: got v=%b pc=%h inst=%h adel=%b want v=%b pc=%h inst=%h adel=%b",
                 k, bus.if_valid, bus.if_pc, bus.if_inst, bus.if_adel, e_v, e_pc, e_inst, e_adel);
      end
      @(negedge clk);
    end
    bus.redirect_valid = 1'b0;
  endtask

  // Redirect in the same cycle decode accepts the head: the pop is void.
  task automatic test_redirect_pop();
    logic        e_req, e_v;
    logic [31:0] e_addr, e_pc;
    start();
    for (int k = 0; k < 8; k++) begin
      bus.if_ready       = 1'b1;
      bus.redirect_valid = (k == 3);
      bus.redirect_pc    = 32'h8000_0300;
      #1;
      e_req  = (k != 3);
      e_addr = (k < 3) ? RST_PC + 32'(4 * k) : 32'h8000_0300 + 32'(4 * (k - 4));
      e_v    = (k == 2) || (k == 3) || (k >= 6);
      e_pc   = (k == 2) ? RST_PC : (k == 3) ? RST_PC + 32'd4 : 32'h8000_0300 + 32'(4 * (k - 6));
      n_tests++;
      if (bus.inst_req !== e_req || (e_req && bus.inst_addr !== e_addr)) begin
        n_fail++;
        $display("FAIL rpop_req c%0d: got req=%b addr=%h want req=%b addr=%h",
                 k, bus.inst_req, bus.inst_addr, e_req, e_addr);
      end
      n_tests++;
      if (bus.if_valid !== e_v ||
          (e_v && {bus.if_pc, bus.if_inst, bus.if_adel} !== {e_pc, e_pc ^ KEY, 1'b0})) begin
        n_fail++;
        $display("FAIL rpop_out c%0d: got v=%b pc=%h inst=%h adel=%b want v=%b pc=%h",
                 k, bus.if_valid, bus.if_pc, bus.if_inst, bus.if_adel, e_v, e_pc);
      end
      @(negedge clk);
    end
    bus.redirect_valid = 1'b0;
  endtask

  // Misaligned redirect at 3 immediately overridden by an aligned one at 4.
  task automatic test_back_to_back();
    logic        e_req, e_v;
    logic [31:0] e_addr, e_pc;
    start();
    for (int k = 0; k < 9; k++) begin
      bus.if_ready       = 1'b1;
      bus.redirect_valid = (k == 3) || (k == 4);
      bus.redirect_pc    = (k == 3) ? 32'h8000_0402 : 32'h8000_0500;
      #1;
      e_req  = (k < 3) || (k > 4);
      e_addr = (k < 3) ? RST_PC + 32'(4 * k) : 32'h8000_0500 + 32'(4 * (k - 5));
      e_v    = (k == 2) || (k == 3) || (k >= 7);
      e_pc   = (k == 2) ? RST_PC : (k == 3) ? RST_PC + 32'd4 : 32'h8000_0500 + 32'(4 * (k - 7));
      n_tests++;
      if (bus.inst_req !== e_req || (e_req && bus.inst_addr !== e_addr)) begin
        n_fail++;
        $display("FAIL b2b_req c%0d: got req=%b addr=%h want req=%b addr=%h",
                 k, bus.inst_req, bus.inst_addr, e_req, e_addr);
      end
      n_tests++;
      if (bus.if_valid !== e_v ||
          (e_v && {bus.if_pc, bus.if_inst, bus.if_adel} !== {e_pc, e_pc ^ KEY, 1'b0})) begin
        n_fail++;
        $display("FAIL b2b_out c%0d: got v=%b pc=%h inst=%h adel=%b want v=%b pc=%h",
                 k, bus.if_valid, bus.if_pc, bus.if_inst, bus.if_adel, e_v, e_pc);
      end
      @(negedge clk);
    end
    bus.redirect_valid = 1'b0;
  endtask

  // One-cycle reset at cycle 4; fetch restarts from RST_PC at cycle 5.
  task automatic test_mid_reset();
    logic        e_req, e_v;
    logic [31:0] e_addr, e_pc;
    start();
    for (int k = 0; k < 9; k++) begin
      bus.if_ready = 1'b1;
      rst = (k == 4);
      #1;
      e_req  = (k != 4);
      e_addr = (k < 4) ? RST_PC + 32'(4 * k) : RST_PC + 32'(4 * (k - 5));
      e_v    = (k >= 2 && k <= 4) || (k >= 7);
      e_pc   = (k <= 4) ? RST_PC + 32'(4 * (k - 2)) : RST_PC + 32'(4 * (k - 7));
      n_tests++;
      if (bus.inst_req !== e_req || (e_req && bus.inst_addr !== e_addr)) begin
        n_fail++;
        $display("FAIL mrst_req c%0d: got req=%b addr=%h want req=%b addr=%h",
                 k, bus.inst_req, bus.inst_addr, e_req, e_addr);
      end
      n_tests++;
      if (k == 5) begin
        if ({bus.if_valid, bus.if_pc, bus.if_inst, bus.if_adel} !== 66'h0) begin
          n_fail++;
          $display("FAIL mrst_out c%0d: got v=%b pc=%h inst=%h adel=%b want all 0",
                   k, bus.if_valid, bus.if_pc, bus.if_inst, bus.if_adel);
        end
      end else if (bus.if_valid !== e_v ||
                   (e_v && {bus.if_pc, bus.if_inst, bus.if_adel} !== {e_pc, e_pc ^ KEY, 1'b0})) begin
        n_fail++;
        $display("FAIL mrst_out c%0d: got v=%b pc=%h inst=%h adel=%b want v=%b pc=%h",
                 k, bus.if_valid, bus.if_pc, bus.if_inst, bus.if_adel, e_v, e_pc);
      end
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  // Redirect to FFFFFFF8 at 2; the PC wraps FFFFFFFC -> 00000000.
  task automatic test_pc_wrap();
    logic        e_req, e_v;
    logic [31:0] e_addr, e_pc;
    start();
    for (int k = 0; k < 9; k++) begin
      bus.if_ready       = 1'b1;
      bus.redirect_valid = (k == 2);
      bus.redirect_pc    = 32'hFFFF_FFF8;
      #1;
      e_req  = (k != 2);
      e_addr = (k < 2) ? RST_PC + 32'(4 * k) : 32'hFFFF_FFF8 + 32'(4 * (k - 3));
      e_v    = (k == 2) || (k >= 5);
      e_pc   = (k == 2) ? RST_PC : 32'hFFFF_FFF8 + 32'(4 * (k - 5));
      n_tests++;
      if (bus.inst_req !== e_req || (e_req && bus.inst_addr !== e_addr)) begin
        n_fail++;
        $display("FAIL wrap_req c%0d: got req=%b addr=%h want req=%b addr=%h",
                 k, bus.inst_req, bus.inst_addr, e_req, e_addr);
      end
      n_tests++;
      if (bus.if_valid !== e_v ||
          (e_v && {bus.if_pc, bus.if_inst, bus.if_adel} !== {e_pc, e_pc ^ KEY, 1'b0})) begin
        n_fail++;
        $display("FAIL wrap_out c%0d: got v=%b pc=%h inst=%h adel=%b want v=%b pc=%h",
                 k, bus.if_valid, bus.if_pc, bus.if_inst, bus.if_adel, e_v, e_pc);
      end
      @(negedge clk);
    end
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_misaligned();
    test_redirect_pop();
    test_back_to_back();
    test_mid_reset();
    test_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
